// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner: walks one active-low row per tick, debounces
// the active-low column reading and emits one key event per press.
module keypad_scan_4x4 #(
    parameter int TICK_CYCLES    = 100_000,
    parameter int DEBOUNCE_TICKS = 8
) (
    input  logic       clock,
    input  logic       reset,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [CW-1:0] TICK_MAX = CW'(TICK_CYCLES - 1);
    localparam logic [DW-1:0] DEB_PRESS = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [DW-1:0] DEB_REL = DW'(DEBOUNCE_TICKS - 2);

    localparam logic [1:0] S_SCAN = 2'd0;
    localparam logic [1:0] S_DEB  = 2'd1;
    localparam logic [1:0] S_HELD = 2'd2;
    localparam logic [1:0] S_REL  = 2'd3;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    col_m_q, col_s_q;
    logic [1:0]    state_q, state_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [3:0]    col_l_q, col_l_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_held_q, key_held_d;
    logic          tick;
    logic          one_low;
    logic          all_high;
    logic [1:0]    col_idx;

    assign row       = ~(4'b0001 << row_idx_q);
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;

    always_comb begin
        tick     = (cnt_q == TICK_MAX);
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        all_high = (col_s_q == 4'hF);
        case (col_s_q)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
            default:                            one_low = 1'b0;
        endcase
        case (col_l_q)
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        col_l_d     = col_l_q;
        deb_cnt_d   = deb_cnt_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        if (tick) begin
            case (state_q)
                S_SCAN: begin
                    if (one_low) begin
                        col_l_d   = col_s_q;
                        deb_cnt_d = '0;
                        state_d   = S_DEB;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
                S_DEB: begin
                    if (col_s_q == col_l_q) begin
                        if (deb_cnt_q == DEB_PRESS) begin
                            key_valid_d = 1'b1;
                            key_code_d  = {row_idx_q, col_idx};
                            key_held_d  = 1'b1;
                            state_d     = S_HELD;
                        end else begin
                            deb_cnt_d = deb_cnt_q + 1'b1;
                        end
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                        state_d   = S_SCAN;
                    end
                end
                S_HELD: begin
                    if (all_high) begin
                        deb_cnt_d = '0;
                        state_d   = S_REL;
                    end
                end
                default: begin
                    // The HELD->RELEASE tick already counted as one released sample.
                    if (!all_high) begin
                        state_d = S_HELD;
                    end else if (deb_cnt_q == DEB_REL) begin
                        key_held_d = 1'b0;
                        row_idx_d  = row_idx_q + 2'd1;
                        state_d    = S_SCAN;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            col_m_q     <= 4'hF;
            col_s_q     <= 4'hF;
            state_q     <= S_SCAN;
            row_idx_q   <= 2'd0;
            col_l_q     <= 4'hF;
            deb_cnt_q   <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            key_held_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            col_m_q     <= col;
            col_s_q     <= col_m_q;
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            col_l_q     <= col_l_d;
            deb_cnt_q   <= deb_cnt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
        end
    end

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Bench for keypad_scan_4x4: keypad matrix model plus key-event scoreboard.
module tb_keypad_scan_4x4;

    logic       clock;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    logic [15:0] pressed;
    int          tb_cnt;
    int          checks;
    int          failures;
    logic [3:0]  exp_q[$];
    logic        prev_kv;

    keypad_scan_4x4 #(
        .TICK_CYCLES(10),
        .DEBOUNCE_TICKS(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .row(row),
        .col(col),
        .key_valid(key_valid),
        .key_code(key_code),
        .key_held(key_held)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
    end

    // Reference tick phase: counter 0..9, tick on the edge leaving 9.
    always @(posedge clock or negedge reset) begin
        if (!reset) tb_cnt <= 0;
        else tb_cnt <= (tb_cnt == 9) ? 0 : tb_cnt + 1;
    end

    initial begin
        prev_kv = 1'b0;
        forever begin
            @(negedge clock);
            if (reset && key_valid) begin
                checks++;
                if (prev_kv) begin
                    failures++;
                    $display("FAIL kv_consecutive got=1 want=0");
                end else if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event code=%0d want=none", key_code);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    if (key_code !== e) begin
                        failures++;
                        $display("FAIL event_code got=%0d want=%0d", key_code, e);
                    end
                end
            end
            prev_kv = key_valid;
        end
    end

    task automatic wait_tick();
        @(negedge clock);
        while (tb_cnt != 9) @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_event(input int budget, input string name);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clock);
        @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s missing_events got=%0d want=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_release(input int budget, input string name);
        for (int i = 0; i < budget && key_held !== 1'b0; i++) @(negedge clock);
        checks++;
        if (key_held !== 1'b0) begin
            failures++;
            $display("FAIL %s held_timeout got=%b want=0", name, key_held);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_row;
        reset = 1'b0;
        pressed = '0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({row, key_valid, key_code, key_held} !== {4'b1110, 1'b0, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outs got=%b_%b_%h_%b want=1110_0_0_0",
                     row, key_valid, key_code, key_held);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock);
            #1;
            if (n == 9 || n == 10 || n == 20 || n == 30 || n == 40) begin
                case (n)
                    9:  exp_row = 4'b1110;
                    10: exp_row = 4'b1101;
                    20: exp_row = 4'b1011;
                    30: exp_row = 4'b0111;
                    default: exp_row = 4'b1110;
                endcase
                checks++;
                if (row !== exp_row) begin
                    failures++;
                    $display("FAIL row_step_%0d got=%b want=%b", n, row, exp_row);
                end
            end
        end
    endtask

    task automatic test_press();
        pressed[2*4+1] = 1'b1;
        exp_q.push_back(4'd9);
        wait_event(400, "press");
        repeat (100) @(posedge clock);
        #1;
        checks++;
        if (key_held !== 1'b1 || key_code !== 4'd9) begin
            failures++;
            $display("FAIL press_hold got=%b/%0d want=1/9", key_held, key_code);
        end
        wait_tick();
        pressed = '0;
        for (int t = 1; t <= 4; t++) begin
            wait_tick();
            checks++;
            if (key_held !== (t < 4)) begin
                failures++;
                $display("FAIL release_tick%0d got=%b want=%b", t, key_held, t < 4);
            end
        end
        checks++;
        if (row !== 4'b0111) begin
            failures++;
            $display("FAIL resume_row got=%b want=0111", row);
        end
    endtask

    task automatic test_bounce();
        int k;
        pressed[1*4+3] = 1'b1;
        k = 0;
        while (row !== 4'b1101 && k < 8) begin
            wait_tick();
            k++;
        end
        wait_tick();
        wait_tick();
        pressed = '0;
        wait_tick();
        checks++;
        if (row !== 4'b1011 || key_held !== 1'b0) begin
            failures++;
            $display("FAIL bounce_abort got=%b/%b want=1011/0", row, key_held);
        end
        pressed[1*4+3] = 1'b1;
        exp_q.push_back(4'd7);
        wait_event(300, "repress");
        pressed = '0;
        wait_release(200, "repress");
    endtask

    task automatic test_multi();
        logic [3:0] prev;
        pressed[0] = 1'b1;
        pressed[3] = 1'b1;
        for (int t = 0; t < 12; t++) begin
            prev = row;
            wait_tick();
            checks++;
            if (row !== {prev[2:0], prev[3]} || key_held !== 1'b0) begin
                failures++;
                $display("FAIL multi_rot%0d got=%b/%b want=%b/0",
                         t, row, key_held, {prev[2:0], prev[3]});
            end
        end
        pressed = '0;
    endtask

    task automatic test_chatter();
        pressed[3*4+2] = 1'b1;
        exp_q.push_back(4'd14);
        wait_event(300, "chatter");
        wait_tick();
        pressed = '0;
        wait_tick();
        wait_tick();
        pressed[3*4+2] = 1'b1;
        wait_tick();
        checks++;
        if (key_held !== 1'b1) begin
            failures++;
            $display("FAIL chatter_back got=%b want=1", key_held);
        end
        pressed = '0;
        for (int t = 1; t <= 4; t++) begin
            wait_tick();
            checks++;
            if (key_held !== (t < 4)) begin
                failures++;
                $display("FAIL chatter_rel%0d got=%b want=%b", t, key_held, t < 4);
            end
        end
        checks++;
        if (key_code !== 4'd14 || row !== 4'b1110) begin
            failures++;
            $display("FAIL chatter_end got=%0d/%b want=14/1110", key_code, row);
        end
    endtask

    task automatic test_reset_held();
        pressed[1*4+1] = 1'b1;
        exp_q.push_back(4'd5);
        wait_event(300, "rst_first");
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if ({row, key_valid, key_code, key_held} !== {4'b1110, 1'b0, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL midreset got=%b_%b_%h_%b want=1110_0_0_0",
                     row, key_valid, key_code, key_held);
        end
        repeat (3) @(posedge clock);
        exp_q.push_back(4'd5);
        @(negedge clock);
        reset = 1'b1;
        wait_event(300, "rst_again");
        checks++;
        if (key_held !== 1'b1 || key_code !== 4'd5) begin
            failures++;
            $display("FAIL rst_redetect got=%b/%0d want=1/5", key_held, key_code);
        end
        pressed = '0;
        wait_release(200, "rst_release");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_press();
        test_bounce();
        test_multi();
        test_chatter();
        test_reset_held();
        repeat (20) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
